pciea_dbg_trace_capture: RTL and testbench
==========================================

// Module: pciea_dbg_trace_capture
// PURPOSE
//  Parametrised successor to the PCIe port debug interface: muxes NUM_CH debug buses (data+ctrl),
//  drives each channel's dbg_sel, and captures the chosen channel into a ring buffer around a
//  ctrl-pattern trigger with programmable post-trigger depth. Sits between the PCIe core debug
//  outputs and the register/readout fabric; replaces the fixed two-channel pass-through.
// PARAMETERS
//  NUM_CH   2    number of debug channels (>=1)
//  DATA_W   256  width of one channel's dbg_data
//  CTRL_W   32   width of one channel's dbg_ctrl
//  SEL_W    6    width of one channel's dbg_sel
//  DEPTH    512  capture buffer entries, power of 2, >=4
// PORTS
//  user_clk      in   1                 single clock for all logic
//  user_reset_n  in   1                 async assert, active-low reset
//  dbg_data_in   in   NUM_CH*DATA_W     channel c at [c*DATA_W +: DATA_W]
//  dbg_ctrl_in   in   NUM_CH*CTRL_W     channel c at [c*CTRL_W +: CTRL_W]
//  dbg_sel_out   out  NUM_CH*SEL_W      registered per-channel select to the core
//  cfg_sel       in   NUM_CH*SEL_W      requested selects; latched only in IDLE
//  cfg_ch        in   $clog2(NUM_CH)    capture channel; latched on arm (use width 1 if NUM_CH==1)
//  trig_mask     in   CTRL_W            ctrl bits compared
//  trig_value    in   CTRL_W            trigger when (ctrl & mask)==(value & mask)
//  post_cnt      in   $clog2(DEPTH)     samples written after the trigger sample
//  arm           in   1                 pulse: start capture (IDLE only)
//  abort         in   1                 pulse: return to IDLE from any state
//  state_out     out  3                 current state encoding (package enum)
//  triggered     out  1                 sticky high from trigger until IDLE
//  rd_valid      out  1                 readout sample valid
//  rd_ready      in   1                 readout sink ready
//  rd_data       out  DATA_W+CTRL_W     {ctrl,data} of sample
//  rd_last       out  1                 final sample of capture, with rd_valid
// BEHAVIOUR
//  Reset: state=IDLE, dbg_sel_out=0, triggered=0, rd_valid=0, rd_last=0, rd_data=0, pointers=0.
//  IDLE: dbg_sel_out <= cfg_sel every cycle. arm -> PRE (cfg_ch, mask, value, post_cnt latched).
//  Input sample registered once; RAM write at cycle after sample (1-cycle input latency).
//  PRE: write every cycle, wr_ptr wraps DEPTH-1->0, set wrapped flag on wrap. Trigger match on
//   registered ctrl -> POST; trigger sample is written; match on first PRE cycle is valid.
//  POST: write post_cnt further samples then -> DONE. post_cnt=0 -> DONE next cycle.
//   post_cnt >= DEPTH-1 is clamped to DEPTH-1 (trigger sample always retained).
//  DONE: one cycle; rd_ptr = wrapped ? wr_ptr : 0; n = wrapped ? DEPTH : wr_ptr -> READ.
//  READ: AXI-style: rd_data/rd_last stable while rd_valid && !rd_ready; transfer on both high.
//   RAM read latency 1; first rd_valid 2 cycles after entering READ. rd_last on sample n-1.
//   After last transfer -> IDLE next cycle; rd_valid low in IDLE.
//  abort: any state -> IDLE next cycle; rd_valid drops same edge; buffer contents discarded.
//  arm outside IDLE ignored; arm and abort same cycle: abort wins.
//  cfg_sel changes outside IDLE ignored (select frozen during capture).
//  Async reset mid-capture or mid-read: all outputs to reset values immediately.
// STRUCTURE
//  Package pciea_dbg_pkg: state enum {IDLE,PRE,POST,DONE,READ} (3 b), localparam helpers for
//   PTR_W=$clog2(DEPTH), SAMPLE_W=DATA_W+CTRL_W, channel slice functions.
//  Sub-module pciea_dbg_ring_ram: simple dual-port DEPTH x SAMPLE_W, 1-cycle registered read.
//  Top holds FSM, channel mux, trigger compare, pointers/counters, readout skid register.
// TESTING
//  1 NUM_CH=2,DEPTH=16; ch1 ctrl=counter, mask=0xFF,value=0x40,post_cnt=3, arm -> 16 samples,
//    last 4 ctrl = 0x40..0x43, first = 0x34, rd_last on 16th.
//  2 Trigger 5 cycles after arm, post_cnt=2 (no wrap) -> exactly 8 samples read, oldest first.
//  3 rd_ready toggled 1/0 each cycle during READ -> no sample dropped/duplicated, data stable.
//  4 abort during POST -> state_out=IDLE next cycle, triggered=0, rd_valid never asserted.
//  5 post_cnt=31 with DEPTH=16 -> clamped, trigger sample is first read, 16 samples total.
//  6 Assert user_reset_n low mid-READ -> rd_valid=0, dbg_sel_out=0 same cycle; rearm works.

Source files
------------

// File: rtl/pciea_dbg_pkg.sv
// Shared types and sizing helpers for the PCIe debug trace-capture block.
package pciea_dbg_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    PRE  = 3'd1,
    POST = 3'd2,
    DONE = 3'd3,
    READ = 3'd4
  } dbg_state_e;

  function automatic int ptr_w(input int depth);
    return $clog2(depth);
  endfunction

  function automatic int sample_w(input int data_w, input int ctrl_w);
    return data_w + ctrl_w;
  endfunction

  // Low bit of channel ch inside a flattened NUM_CH*w bus
  function automatic int ch_lsb(input int ch, input int w);
    return ch * w;
  endfunction

endpackage

// File: rtl/pciea_dbg_ring_ram.sv
// Simple dual-port capture memory with a one-cycle registered read port.
module pciea_dbg_ring_ram #(
  parameter int DEPTH = 512,
  parameter int WIDTH = 288,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // rdata holds its value when re is low so the reader can stall on it
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/pciea_dbg_trace_capture.sv
// Debug-bus mux and ring-buffer trace capture around a ctrl-pattern trigger,
// with a valid/ready readout of the captured window, oldest sample first.
module pciea_dbg_trace_capture
  import pciea_dbg_pkg::*;
#(
  parameter int NUM_CH = 2,
  parameter int DATA_W = 256,
  parameter int CTRL_W = 32,
  parameter int SEL_W  = 6,
  parameter int DEPTH  = 512,
  localparam int CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  localparam int PTR_W    = ptr_w(DEPTH),
  localparam int SAMPLE_W = sample_w(DATA_W, CTRL_W)
) (
  input  logic                     user_clk,
  input  logic                     user_reset_n,
  input  logic [NUM_CH*DATA_W-1:0] dbg_data_in,
  input  logic [NUM_CH*CTRL_W-1:0] dbg_ctrl_in,
  output logic [NUM_CH*SEL_W-1:0]  dbg_sel_out,
  input  logic [NUM_CH*SEL_W-1:0]  cfg_sel,
  input  logic [CH_W-1:0]          cfg_ch,
  input  logic [CTRL_W-1:0]        trig_mask,
  input  logic [CTRL_W-1:0]        trig_value,
  input  logic [PTR_W-1:0]         post_cnt,
  input  logic                     arm,
  input  logic                     abort,
  output logic [2:0]               state_out,
  output logic                     triggered,
  output logic                     rd_valid,
  input  logic                     rd_ready,
  output logic [SAMPLE_W-1:0]      rd_data,
  output logic                     rd_last
);

  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
  localparam logic [PTR_W:0]   FULL_N   = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W:0]   ONE_N    = (PTR_W+1)'(1);

  dbg_state_e          state_q, state_d;
  logic [CH_W-1:0]     ch_q, ch_mux;
  logic [CTRL_W-1:0]   mask_q, value_q;
  logic [PTR_W-1:0]    wr_ptr_q, rd_ptr_q, post_rem_q;
  logic [PTR_W:0]      issue_rem_q;
  logic                wrapped_q;
  logic [DATA_W-1:0]   ch_data, data_p0;
  logic [CTRL_W-1:0]   ch_ctrl, ctrl_p0;
  logic [SAMPLE_W-1:0] ram_rdata;
  logic                vld_p1, last_p1;
  logic                arm_take, hit, wr_en, rd_en, out_take, flush, last_xfer;

  function automatic logic trig_match(input logic [CTRL_W-1:0] c,
                                      input logic [CTRL_W-1:0] m,
                                      input logic [CTRL_W-1:0] v);
    return ((c ^ v) & m) == '0;
  endfunction

  // The trigger sample must always survive, so at most DEPTH-1 follow it
  function automatic logic [PTR_W-1:0] clamp_post(input logic [PTR_W-1:0] p);
    return (p > LAST_PTR) ? LAST_PTR : p;
  endfunction

  assign state_out = state_q;
  assign arm_take  = (state_q == IDLE) && arm && !abort;
  assign ch_mux    = (state_q == IDLE) ? cfg_ch : ch_q;

  always_comb begin
    ch_data = dbg_data_in[DATA_W-1:0];
    ch_ctrl = dbg_ctrl_in[CTRL_W-1:0];
    for (int c = 1; c < NUM_CH; c++) begin
      if (ch_mux == CH_W'(c)) begin
        ch_data = dbg_data_in[ch_lsb(c, DATA_W) +: DATA_W];
        ch_ctrl = dbg_ctrl_in[ch_lsb(c, CTRL_W) +: CTRL_W];
      end
    end
  end

  // Stage p0: selected channel registered once; trigger and RAM write both use it
  always_ff @(posedge user_clk) begin
    data_p0 <= ch_data;
    ctrl_p0 <= ch_ctrl;
    if (arm_take) begin
      ch_q    <= cfg_ch;
      mask_q  <= trig_mask;
      value_q <= trig_value;
    end
  end

  always_comb begin
    state_d   = state_q;
    hit       = 1'b0;
    wr_en     = 1'b0;
    last_xfer = rd_valid && rd_ready && rd_last;
    unique case (state_q)
      IDLE: if (arm) state_d = PRE;
      PRE: begin
        wr_en = 1'b1;
        hit   = trig_match(ctrl_p0, mask_q, value_q);
        if (hit) state_d = (post_rem_q == '0) ? DONE : POST;
      end
      POST: begin
        wr_en = 1'b1;
        if (post_rem_q == PTR_W'(1)) state_d = DONE;
      end
      DONE:    state_d = READ;
      READ:    if (last_xfer) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (abort) state_d = IDLE;
  end

  always_ff @(posedge user_clk or negedge user_reset_n) begin
    if (!user_reset_n) begin
      state_q     <= IDLE;
      dbg_sel_out <= '0;
      triggered   <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      wrapped_q   <= 1'b0;
      post_rem_q  <= '0;
      issue_rem_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE) dbg_sel_out <= cfg_sel;
      if (state_d == IDLE)  triggered <= 1'b0;
      else if (hit)         triggered <= 1'b1;
      if (arm_take) begin
        wr_ptr_q   <= '0;
        wrapped_q  <= 1'b0;
        post_rem_q <= clamp_post(post_cnt);
      end else if (wr_en) begin
        wr_ptr_q <= wr_ptr_q + PTR_W'(1);
        if (wr_ptr_q == LAST_PTR) wrapped_q <= 1'b1;
        if (state_q == POST) post_rem_q <= post_rem_q - PTR_W'(1);
      end
      // Once wrapped, the oldest surviving sample sits at the write pointer
      if (state_q == DONE) begin
        rd_ptr_q    <= wrapped_q ? wr_ptr_q : '0;
        issue_rem_q <= wrapped_q ? FULL_N : {1'b0, wr_ptr_q};
      end else if (rd_en) begin
        rd_ptr_q    <= rd_ptr_q + PTR_W'(1);
        issue_rem_q <= issue_rem_q - ONE_N;
      end
    end
  end

  assign flush    = abort || (state_q != READ);
  assign out_take = !rd_valid || rd_ready;
  assign rd_en    = !flush && (issue_rem_q != '0) && (!vld_p1 || out_take);

  // Stage p1: RAM output (held while stalled); stage p2: rd_data output register
  always_ff @(posedge user_clk or negedge user_reset_n) begin
    if (!user_reset_n) begin
      vld_p1   <= 1'b0;
      last_p1  <= 1'b0;
      rd_valid <= 1'b0;
      rd_last  <= 1'b0;
      rd_data  <= '0;
    end else if (flush) begin
      vld_p1   <= 1'b0;
      rd_valid <= 1'b0;
      rd_last  <= 1'b0;
    end else begin
      if (rd_en) begin
        vld_p1  <= 1'b1;
        last_p1 <= (issue_rem_q == ONE_N);
      end else if (out_take) begin
        vld_p1 <= 1'b0;
      end
      if (out_take) begin
        rd_valid <= vld_p1;
        rd_last  <= vld_p1 && last_p1;
        if (vld_p1) rd_data <= ram_rdata;
      end
    end
  end

  pciea_dbg_ring_ram #(
    .DEPTH (DEPTH),
    .WIDTH (SAMPLE_W)
  ) u_ram (
    .clk   (user_clk),
    .we    (wr_en),
    .waddr (wr_ptr_q),
    .wdata ({ctrl_p0, data_p0}),
    .re    (rd_en),
    .raddr (rd_ptr_q),
    .rdata (ram_rdata)
  );

endmodule

// File: tb/tb_pciea_dbg_trace_capture.sv
// Randomized scoreboard bench for pciea_dbg_trace_capture (NUM_CH=2, DEPTH=16).
module tb_pciea_dbg_trace_capture;

  localparam int NUM_CH = 2;
  localparam int DATA_W = 64;
  localparam int CTRL_W = 16;
  localparam int SEL_W  = 6;
  localparam int DEPTH  = 16;
  localparam int PTR_W  = 4;
  localparam int CH_W   = 1;
  localparam int SELB   = NUM_CH * SEL_W;
  localparam int SAMPLE_W = DATA_W + CTRL_W;

  typedef struct {
    logic [CTRL_W-1:0] ctrl;
    logic [DATA_W-1:0] data;
    logic              last;
  } exp_t;

  logic                     clk = 1'b0;
  logic                     user_reset_n;
  logic [NUM_CH*DATA_W-1:0] dbg_data_in;
  logic [NUM_CH*CTRL_W-1:0] dbg_ctrl_in;
  logic [SELB-1:0]          dbg_sel_out;
  logic [SELB-1:0]          cfg_sel;
  logic [CH_W-1:0]          cfg_ch;
  logic [CTRL_W-1:0]        trig_mask, trig_value;
  logic [PTR_W-1:0]         post_cnt;
  logic                     arm, abort;
  logic [2:0]               state_out;
  logic                     triggered, rd_valid, rd_ready, rd_last;
  logic [SAMPLE_W-1:0]      rd_data;

  int   n_cmp = 0;
  int   n_bad = 0;
  int   pops  = 0;
  int   ready_mode = 0;
  logic [CTRL_W-1:0] cnt = '0;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  pciea_dbg_trace_capture #(
    .NUM_CH(NUM_CH), .DATA_W(DATA_W), .CTRL_W(CTRL_W), .SEL_W(SEL_W), .DEPTH(DEPTH)
  ) dut (
    .user_clk(clk), .user_reset_n(user_reset_n),
    .dbg_data_in(dbg_data_in), .dbg_ctrl_in(dbg_ctrl_in), .dbg_sel_out(dbg_sel_out),
    .cfg_sel(cfg_sel), .cfg_ch(cfg_ch), .trig_mask(trig_mask), .trig_value(trig_value),
    .post_cnt(post_cnt), .arm(arm), .abort(abort), .state_out(state_out),
    .triggered(triggered), .rd_valid(rd_valid), .rd_ready(rd_ready),
    .rd_data(rd_data), .rd_last(rd_last)
  );

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Non-trigger ctrl keeps bit 15 clear; trigger values always have it set
  task automatic drive_inputs(input bit use_cnt, input bit force_trig, input logic [CTRL_W-1:0] tv);
    for (int c = 0; c < NUM_CH; c++) begin
      dbg_data_in[c*DATA_W +: DATA_W] = {$urandom, $urandom};
      if (force_trig)   dbg_ctrl_in[c*CTRL_W +: CTRL_W] = tv;
      else if (use_cnt) dbg_ctrl_in[c*CTRL_W +: CTRL_W] = (c == 1) ? cnt : cnt + 16'h1000;
      else              dbg_ctrl_in[c*CTRL_W +: CTRL_W] = CTRL_W'($urandom) & 16'h7FFF;
    end
    cnt = cnt + 1'b1;
  endtask

  // Drives one capture and pushes the samples the ring must hand back
  task automatic run_capture(input int ch, input logic [CTRL_W-1:0] mask,
                             input logic [CTRL_W-1:0] value, input logic [PTR_W-1:0] post,
                             input bit use_cnt, input int trig_at);
    exp_t rec[$];
    exp_t s;
    logic [SELB-1:0] sel_a;
    int tidx = -1;
    int p_eff;
    int first;
    bit done = 0;
    p_eff = (int'(post) > DEPTH - 1) ? DEPTH - 1 : int'(post);
    sel_a = SELB'($urandom);
    cfg_sel = sel_a; cfg_ch = CH_W'(ch); trig_mask = mask; trig_value = value; post_cnt = post;
    @(posedge clk); #1;
    check("sel_idle", dbg_sel_out, sel_a);
    for (int i = 0; i < 100 && !done; i++) begin
      if (i > 0) begin @(posedge clk); #1; end
      arm = (i == 0);
      drive_inputs(use_cnt, i == trig_at, value);
      if (i == 1) cfg_sel = SELB'($urandom);
      if (i == 2) check("sel_frozen", dbg_sel_out, sel_a);
      s.ctrl = dbg_ctrl_in[ch*CTRL_W +: CTRL_W];
      s.data = dbg_data_in[ch*DATA_W +: DATA_W];
      s.last = 1'b0;
      rec.push_back(s);
      if (tidx < 0 && ((s.ctrl ^ value) & mask) == '0) tidx = i;
      if (tidx >= 0 && rec.size() == tidx + 1 + p_eff) done = 1;
    end
    @(posedge clk); #1;
    arm = 1'b0;
    check("capture_complete", done, 1'b1);
    first = (rec.size() > DEPTH) ? rec.size() - DEPTH : 0;
    for (int k = first; k < rec.size(); k++) begin
      s = rec[k];
      s.last = (k == rec.size() - 1);
      exp_q.push_back(s);
    end
  endtask

  task automatic wait_done(input bit poke_arm);
    bit ok = 0;
    bit poked = 0;
    for (int i = 0; i < 400; i++) begin
      @(posedge clk); #1;
      arm = 1'b0;
      if (poke_arm && !poked && state_out == 3'd4) begin arm = 1'b1; poked = 1; end
      if (exp_q.size() == 0 && state_out == 3'd0) begin ok = 1; break; end
    end
    arm = 1'b0;
    check("readout_done", ok, 1'b1);
    check("idle_rd_valid", rd_valid, 1'b0);
    exp_q.delete();
  endtask

  initial begin
    forever begin
      @(posedge clk); #1;
      case (ready_mode)
        0:       rd_ready = 1'b1;
        1:       rd_ready = ~rd_ready;
        default: rd_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Monitor: pops and compares on every handshake, checks hold while stalled
  initial begin
    exp_t e;
    bit stall = 0;
    logic [SAMPLE_W-1:0] hold_data = '0;
    logic hold_last = 1'b0;
    forever begin
      @(negedge clk);
      if (!user_reset_n) begin stall = 0; continue; end
      if (rd_valid) begin
        if (stall) begin
          check("hold_data", rd_data, hold_data);
          check("hold_last", rd_last, hold_last);
        end
        if (exp_q.size() == 0) check("unexpected_rd_valid", rd_valid, 1'b0);
        else if (rd_ready) begin
          e = exp_q.pop_front();
          check("rd_data", rd_data, {e.ctrl, e.data});
          check("rd_last", rd_last, e.last);
          pops++;
        end
        stall = !rd_ready;
        hold_data = rd_data;
        hold_last = rd_last;
      end else begin
        stall = 0;
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int target;
    bit ok;
    user_reset_n = 1'b0; rd_ready = 1'b1;
    dbg_data_in = '0; dbg_ctrl_in = '0; cfg_sel = '1; cfg_ch = '0;
    trig_mask = '0; trig_value = '0; post_cnt = '0; arm = 1'b0; abort = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_state", state_out, 3'd0);
    check("rst_sel", dbg_sel_out, '0);
    check("rst_trig", triggered, 1'b0);
    check("rst_valid", rd_valid, 1'b0);
    check("rst_last", rd_last, 1'b0);
    check("rst_data", rd_data, '0);
    user_reset_n = 1'b1;

    // arm together with abort: abort wins
    @(posedge clk); #1;
    arm = 1'b1; abort = 1'b1;
    @(posedge clk); #1;
    arm = 1'b0; abort = 1'b0;
    check("arm_abort_idle", state_out, 3'd0);

    // counter on ch1, trigger at low byte 0x40, wrapped window 0x34..0x43
    ready_mode = 0;
    cnt = 16'h0030;
    run_capture(1, 16'h00FF, 16'h0040, 4'd3, 1'b1, -1);
    wait_done(1'b0);

    // trigger 5 cycles after arm, post 2: eight samples, no wrap
    run_capture(0, 16'hFFFF, 16'h8A5A, 4'd2, 1'b0, 5);
    wait_done(1'b0);

    // ready toggling, wrapped capture, arm poked during READ
    ready_mode = 1;
    run_capture(1, 16'h80F0, 16'h80B0, 4'd6, 1'b0, 12);
    wait_done(1'b1);

    // abort during POST
    ready_mode = 0;
    cfg_ch = 1'b0; trig_mask = 16'hFFFF; trig_value = 16'h8123; post_cnt = 4'd10;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      arm = (i == 0);
      abort = (i == 5);
      drive_inputs(1'b0, i == 2, trig_value);
      if (i == 5) begin
        @(negedge clk);
        check("abort_pre_state", state_out, 3'd2);
        check("abort_pre_trig", triggered, 1'b1);
      end
      if (i == 6) begin
        @(negedge clk);
        check("abort_state", state_out, 3'd0);
        check("abort_trig", triggered, 1'b0);
      end
    end
    abort = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    check("abort_no_valid", rd_valid, 1'b0);

    // post_cnt of 31 as seen on a 4-bit port: clamped, trigger sample read first
    run_capture(1, 16'hFFFF, 16'h9999, PTR_W'(31), 1'b0, 3);
    wait_done(1'b0);

    // async reset in the middle of READ, then rearm
    run_capture(0, 16'hFF00, 16'h8800, 4'd12, 1'b0, 7);
    target = pops + 3;
    ok = 0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      if (pops >= target) begin ok = 1; break; end
    end
    check("reset_reached_read", ok, 1'b1);
    #2;
    user_reset_n = 1'b0;
    #1;
    check("midrd_valid", rd_valid, 1'b0);
    check("midrd_sel", dbg_sel_out, '0);
    check("midrd_state", state_out, 3'd0);
    check("midrd_trig", triggered, 1'b0);
    exp_q.delete();
    @(posedge clk); #1;
    user_reset_n = 1'b1;
    run_capture(1, 16'hFFFF, 16'h8F0F, 4'd4, 1'b0, 2);
    wait_done(1'b0);

    // randomized captures with random backpressure
    ready_mode = 2;
    for (int r = 0; r < 6; r++) begin
      run_capture(int'($urandom_range(0, NUM_CH - 1)),
                  16'h8000 | CTRL_W'($urandom), 16'h8000 | CTRL_W'($urandom),
                  PTR_W'($urandom_range(0, 15)), 1'b0, int'($urandom_range(0, 25)));
      wait_done(1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
